// File: rtl/stall_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: tracks E/M/W destination tags
// and Tnew counters, and produces the stall and forwarding-mux selects.
module stall_ctrl #(
  parameter int unsigned NREG = 5,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREG-1:0] d_rs,
  input  logic [NREG-1:0] d_rt,
  input  logic [1:0]      d_tuse_rs,
  input  logic [1:0]      d_tuse_rt,
  input  logic [NREG-1:0] d_dst,
  input  logic [1:0]      d_tnew,
  output logic            stall,
  output logic [1:0]      fwd_rs_d,
  output logic [1:0]      fwd_rt_d,
  output logic [1:0]      fwd_rs_e,
  output logic [1:0]      fwd_rt_e,
  output logic            fwd_rt_m,
  output logic [CNTW-1:0] stall_cnt
);

  logic [NREG-1:0] r_e_dst;
  logic [1:0]      r_e_tnew;
  logic [NREG-1:0] r_e_rs;
  logic [NREG-1:0] r_e_rt;
  logic [NREG-1:0] r_m_dst;
  logic [1:0]      r_m_tnew;
  logic [NREG-1:0] r_m_rt;
  logic [NREG-1:0] r_w_dst;
  logic [CNTW-1:0] r_stall_cnt;

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic hazard(
    input logic [NREG-1:0] r,
    input logic [1:0]      tuse,
    input logic [NREG-1:0] e_dst,
    input logic [1:0]      e_tnew,
    input logic [NREG-1:0] m_dst,
    input logic [1:0]      m_tnew
  );
    return (r != '0) && (tuse != 2'd3) &&
           (((e_dst == r) && (e_tnew > tuse)) || ((m_dst == r) && (m_tnew > tuse)));
  endfunction

  // A matching stage whose result is not ready yet blocks older stages.
  function automatic logic [1:0] fwd_d_sel(
    input logic [NREG-1:0] r,
    input logic [NREG-1:0] e_dst,
    input logic [1:0]      e_tnew,
    input logic [NREG-1:0] m_dst,
    input logic [1:0]      m_tnew,
    input logic [NREG-1:0] w_dst
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (r == '0)
      sel = 2'd0;
    else if (e_dst == r)
      sel = (e_tnew == 2'd0) ? 2'd1 : 2'd0;
    else if (m_dst == r)
      sel = (m_tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (w_dst == r)
      sel = 2'd3;
    return sel;
  endfunction

  function automatic logic [1:0] fwd_e_sel(
    input logic [NREG-1:0] r,
    input logic [NREG-1:0] m_dst,
    input logic [1:0]      m_tnew,
    input logic [NREG-1:0] w_dst
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (r == '0)
      sel = 2'd0;
    else if ((m_dst == r) && (m_tnew == 2'd0))
      sel = 2'd1;
    else if (w_dst == r)
      sel = 2'd2;
    return sel;
  endfunction

  always_comb begin
    w_stall_rs = hazard(d_rs, d_tuse_rs, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew);
    w_stall_rt = hazard(d_rt, d_tuse_rt, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew);
    w_stall    = w_stall_rs | w_stall_rt;
  end

  always_comb begin
    fwd_rs_d = fwd_d_sel(d_rs, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst);
    fwd_rt_d = fwd_d_sel(d_rt, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst);
    fwd_rs_e = fwd_e_sel(r_e_rs, r_m_dst, r_m_tnew, r_w_dst);
    fwd_rt_e = fwd_e_sel(r_e_rt, r_m_dst, r_m_tnew, r_w_dst);
    fwd_rt_m = (r_m_rt != '0) && (r_w_dst == r_m_rt);
  end

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e_dst  <= '0;
      r_e_tnew <= '0;
      r_e_rs   <= '0;
      r_e_rt   <= '0;
      r_m_dst  <= '0;
      r_m_tnew <= '0;
      r_m_rt   <= '0;
      r_w_dst  <= '0;
    end else begin
      if (w_stall) begin
        r_e_dst  <= '0;
        r_e_tnew <= '0;
        r_e_rs   <= '0;
        r_e_rt   <= '0;
      end else begin
        r_e_dst  <= d_dst;
        r_e_tnew <= d_tnew;
        r_e_rs   <= d_rs;
        r_e_rt   <= d_rt;
      end
      r_m_dst  <= r_e_dst;
      r_m_tnew <= dec_sat(r_e_tnew);
      r_m_rt   <= r_e_rt;
      r_w_dst  <= r_m_dst;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed vector bench for stall_ctrl: per-cycle {D inputs, expected outputs} stream
// plus reset and counter-saturation sequences.
module tb_stall_ctrl;

  logic        clk;
  logic        reset_n;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic [4:0]  d_dst;
  logic [1:0]  d_tnew;
  logic        stall;
  logic [1:0]  fwd_rs_d;
  logic [1:0]  fwd_rt_d;
  logic [1:0]  fwd_rs_e;
  logic [1:0]  fwd_rt_e;
  logic        fwd_rt_m;
  logic [31:0] stall_cnt;

  logic        s_stall;
  logic [1:0]  s_fwd_rs_d;
  logic [1:0]  s_fwd_rt_d;
  logic [1:0]  s_fwd_rs_e;
  logic [1:0]  s_fwd_rt_e;
  logic        s_fwd_rt_m;
  logic [1:0]  s_stall_cnt;

  int unsigned total;
  int unsigned bad;

  stall_ctrl #(.NREG(5), .CNTW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .stall_cnt(stall_cnt)
  );

  // Narrow counter copy to exercise saturation within a short run.
  stall_ctrl #(.NREG(5), .CNTW(2)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew),
    .stall(s_stall), .fwd_rs_d(s_fwd_rs_d), .fwd_rt_d(s_fwd_rt_d),
    .fwd_rs_e(s_fwd_rs_e), .fwd_rt_e(s_fwd_rt_e), .fwd_rt_m(s_fwd_rt_m),
    .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [1:0]  tu_rs;
    logic [1:0]  tu_rt;
    logic [4:0]  dst;
    logic [1:0]  tnew;
    logic        e_stall;
    logic [1:0]  e_rs_d;
    logic [1:0]  e_rt_d;
    logic [1:0]  e_rs_e;
    logic [1:0]  e_rt_e;
    logic        e_rt_m;
    int unsigned e_cnt;
  } vec_t;

  localparam int NV = 37;
  vec_t vt [NV];

  function automatic vec_t mk(
    input int rs, input int rt, input int tu_rs, input int tu_rt, input int dst, input int tnew,
    input int st, input int rsd, input int rtd, input int rse, input int rte, input int rtm,
    input int cnt
  );
    vec_t v;
    v.rs = 5'(rs);  v.rt = 5'(rt);  v.tu_rs = 2'(tu_rs);  v.tu_rt = 2'(tu_rt);
    v.dst = 5'(dst);  v.tnew = 2'(tnew);
    v.e_stall = 1'(st);  v.e_rs_d = 2'(rsd);  v.e_rt_d = 2'(rtd);
    v.e_rs_e = 2'(rse);  v.e_rt_e = 2'(rte);  v.e_rt_m = 1'(rtm);
    v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%0d expected=%0d", name, row, act, exp);
    end
  endtask

  task automatic drive(input int rs, input int rt, input int tu_rs, input int tu_rt,
                       input int dst, input int tnew);
    d_rs = 5'(rs);  d_rt = 5'(rt);  d_tuse_rs = 2'(tu_rs);  d_tuse_rt = 2'(tu_rt);
    d_dst = 5'(dst);  d_tnew = 2'(tnew);
  endtask

  task automatic chk_quiet(input string tag, input int row);
    chk({tag, "_stall"}, row, {31'd0, stall}, 32'd0);
    chk({tag, "_fwd_rs_d"}, row, {30'd0, fwd_rs_d}, 32'd0);
    chk({tag, "_fwd_rt_d"}, row, {30'd0, fwd_rt_d}, 32'd0);
    chk({tag, "_fwd_rs_e"}, row, {30'd0, fwd_rs_e}, 32'd0);
    chk({tag, "_fwd_rt_e"}, row, {30'd0, fwd_rt_e}, 32'd0);
    chk({tag, "_fwd_rt_m"}, row, {31'd0, fwd_rt_m}, 32'd0);
    chk({tag, "_cnt"}, row, stall_cnt, 32'd0);
    chk({tag, "_sat_cnt"}, row, {30'd0, s_stall_cnt}, 32'd0);
  endtask

  initial begin
    int unsigned sat_exp;
    total = 0;
    bad   = 0;

    // mk(rs, rt, tuse_rs, tuse_rt, dst, tnew, stall, rs_d, rt_d, rs_e, rt_e, rt_m, cnt)
    vt[0]  = mk( 2,  0, 1, 3,  1, 2,  0, 0, 0, 0, 0, 0, 0); // lw $1
    vt[1]  = mk( 1,  3, 1, 1,  4, 1,  1, 0, 0, 0, 0, 0, 0); // addu uses $1
    vt[2]  = mk( 1,  3, 1, 1,  4, 1,  0, 0, 0, 0, 0, 0, 1);
    vt[3]  = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 2, 0, 0, 1);
    vt[4]  = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 1);
    vt[5]  = mk( 4,  0, 1, 3,  0, 0,  0, 3, 0, 0, 0, 0, 1); // W forward of $4
    vt[6]  = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 1);
    vt[7]  = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 1);
    vt[8]  = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 1);
    vt[9]  = mk( 2,  3, 1, 1,  1, 1,  0, 0, 0, 0, 0, 0, 1); // addu $1
    vt[10] = mk( 1,  6, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 1); // beq uses $1
    vt[11] = mk( 1,  6, 0, 0,  0, 0,  0, 2, 0, 0, 0, 0, 2);
    vt[12] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 2, 0, 0, 2);
    vt[13] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 2);
    vt[14] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 2);
    vt[15] = mk( 2,  0, 1, 3,  1, 2,  0, 0, 0, 0, 0, 0, 2); // lw $1
    vt[16] = mk( 5,  1, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 2); // beq rt=$1
    vt[17] = mk( 5,  1, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 3);
    vt[18] = mk( 5,  1, 0, 0,  0, 0,  0, 0, 3, 0, 0, 0, 4);
    vt[19] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 4);
    vt[20] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 4);
    vt[21] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 4);
    vt[22] = mk( 2,  0, 1, 3,  0, 2,  0, 0, 0, 0, 0, 0, 4); // lw $0
    vt[23] = mk( 0,  0, 1, 1,  3, 1,  0, 0, 0, 0, 0, 0, 4); // addu rs=rt=$0
    vt[24] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 4);
    vt[25] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 4);
    vt[26] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 4);
    vt[27] = mk( 1,  2, 1, 1,  5, 1,  0, 0, 0, 0, 0, 0, 4); // addu $5
    vt[28] = mk( 6,  5, 1, 2,  0, 0,  0, 0, 0, 0, 0, 0, 4); // sw rt=$5
    vt[29] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 1, 0, 4);
    vt[30] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 1, 4);
    vt[31] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 0, 0, 0, 4);
    vt[32] = mk( 0,  0, 3, 3, 31, 0,  0, 0, 0, 0, 0, 0, 4); // jal: $31 ready in E
    vt[33] = mk(31, 31, 1, 1,  2, 1,  0, 1, 1, 0, 0, 0, 4);
    vt[34] = mk( 2, 31, 0, 0,  0, 0,  1, 0, 2, 1, 1, 0, 4);
    vt[35] = mk( 2, 31, 0, 0,  0, 0,  0, 2, 3, 0, 0, 1, 5);
    vt[36] = mk( 0,  0, 3, 3,  0, 0,  0, 0, 0, 2, 0, 0, 5);

    // Reset with non-trivial D inputs: every output must still be 0.
    reset_n = 1'b0;
    drive(1, 1, 0, 0, 1, 2);
    repeat (2) @(negedge clk);
    #1 chk_quiet("reset", -1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(int'(vt[i].rs), int'(vt[i].rt), int'(vt[i].tu_rs), int'(vt[i].tu_rt),
            int'(vt[i].dst), int'(vt[i].tnew));
      #1;
      chk("stall",    i, {31'd0, stall},    {31'd0, vt[i].e_stall});
      chk("fwd_rs_d", i, {30'd0, fwd_rs_d}, {30'd0, vt[i].e_rs_d});
      chk("fwd_rt_d", i, {30'd0, fwd_rt_d}, {30'd0, vt[i].e_rt_d});
      chk("fwd_rs_e", i, {30'd0, fwd_rs_e}, {30'd0, vt[i].e_rs_e});
      chk("fwd_rt_e", i, {30'd0, fwd_rt_e}, {30'd0, vt[i].e_rt_e});
      chk("fwd_rt_m", i, {31'd0, fwd_rt_m}, {31'd0, vt[i].e_rt_m});
      chk("stall_cnt", i, stall_cnt, vt[i].e_cnt);
      sat_exp = (vt[i].e_cnt > 3) ? 3 : vt[i].e_cnt;
      chk("sat_cnt", i, {30'd0, s_stall_cnt}, sat_exp);
    end

    // lw $1 then dependent addu; reset mid-cycle while the stall is pending.
    @(negedge clk);
    drive(2, 0, 1, 3, 1, 2);
    @(negedge clk);
    drive(1, 3, 1, 1, 4, 1);
    #1 chk("pre_reset_stall", 100, {31'd0, stall}, 32'd1);
    chk("pre_reset_cnt", 100, stall_cnt, 32'd5);
    #1 reset_n = 1'b0;
    #1 chk_quiet("mid_reset", 101);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk_quiet("post_reset", 102);
    @(negedge clk);
    #1 chk_quiet("post_reset2", 103);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline hazard controller for the five-stage MIPS core: consumes the per-instruction Tuse/Tnew codes produced by the D-stage hazard decoder, tracks destination-register tags and remaining-Tnew counters for the instructions in E, M and W, and produces the stall and forwarding-mux selects. It sits between the D-stage decoder and the pipeline-register enables and clears and the forwarding muxes in D, E and M.

## Interface
- `NREG`, 5: register-index width.
- `CNTW`, 32: stall performance-counter width.

- `clk`  in  1  sole clock; all registers update on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `d_rs`, `d_rt`  in  NREG  source register indices of the D-stage instruction.
- `d_tuse_rs`, `d_tuse_rt`  in  2  Tuse for rs and rt; 3 means the operand is unused.
- `d_dst`  in  NREG  destination register of the D-stage instruction; 0 means no write.
- `d_tnew`  in  2  Tnew the instruction will carry on entering E (0..2).
- `stall`  out  1  combinational; freezes PC and F/D, clears D/E.
- `fwd_rs_d`, `fwd_rt_d`  out  2  D-stage operand select: 0 = regfile, 1 = E, 2 = M, 3 = W.
- `fwd_rs_e`, `fwd_rt_e`  out  2  E-stage operand select: 0 = D/E register, 1 = M, 2 = W.
- `fwd_rt_m`  out  1  M-stage store-data select: 0 = E/M register, 1 = W.
- `stall_cnt`  out  CNTW  number of stall cycles since reset; saturates at all-ones.

## Operation
- Tag registers per stage X in {E, M, W}: `X_dst` (NREG), `X_tnew` (2). E and M also keep `X_rs` and `X_rt`; only `M_rt` is needed in M.
- Every edge:
  - If `stall` is high, E loads a bubble: dst 0, tnew 0, rs 0, rt 0.
  - Otherwise E loads `d_dst`, `d_tnew`, `d_rs`, `d_rt`.
  - M loads E with tnew decremented, saturating at 0.
  - W loads M with tnew decremented, saturating at 0.
  - M and W are never held.
- Stall, combinational:
  - `stall_rs` = `d_rs`≠0 & `d_tuse_rs`≠3 & ((`E_dst`==`d_rs` & `E_tnew`>`d_tuse_rs`) | (`M_dst`==`d_rs` & `M_tnew`>`d_tuse_rs`)).
  - `stall_rt` is the same expression using rt.
  - `stall` = `stall_rs` | `stall_rt`.
  - W never causes a stall.
- D forwarding, per operand r:
  - r==0 gives 0.
  - Otherwise priority: E (`E_dst`==r & `E_tnew`==0) gives 1; else M (`M_dst`==r & `M_tnew`==0) gives 2; else W (`W_dst`==r) gives 3; else 0.
  - A matching stage whose tnew is nonzero blocks lower-priority stages, so stale data is never forwarded. The stall covers that case.
- E forwarding, per `E_rs`/`E_rt`:
  - r==0 gives 0.
  - Otherwise M match with `M_tnew`==0 gives 1; else W match gives 2; else 0.
- M forwarding: `fwd_rt_m` = `M_rt`≠0 & `W_dst`==`M_rt`.
- Equal-priority comparisons are on full NREG-bit indices. Register 0 never matches.
- `stall_cnt` increments on each edge sampled with `stall`=1 and saturates at 2^CNTW−1.

## Timing
- Reset (asynchronous, `reset_n` low): all tag registers go to 0 and `stall_cnt` goes to 0.
  - During reset and immediately after release, `stall`=0 and every fwd output is 0, independent of D inputs, since all destinations are 0.
- `stall` and all fwd selects are combinational from the D inputs and tag registers in the same cycle. There is no registered latency.
- A bubble appears in E one edge after `stall` is sampled high.
- Load-use stalls:
  - Load followed by a dependent ALU op stalls exactly 1 cycle.
  - Load followed by a dependent branch or jr stalls 2 cycles.
  - ALU op followed by a dependent branch stalls 1 cycle.
- Reset asserted mid-stall clears all tags immediately. Pending stall cycles are dropped and the counter clears.
- If a stall and a W-stage writeback coincide, W still advances; the W forward select reflects the current `W_dst`.

## Test plan
- `lw $1` (dst 1, tnew 2) then `addu` rs=1 (tuse 1):
  - `stall`=1 for one cycle.
  - Next cycle `stall`=0, `M_tnew`=1.
  - After `addu` enters E, `fwd_rs_e`=2.
  - `stall_cnt`=1.
- `addu $1` (tnew 1) then `beq` rs=1 (tuse 0):
  - `stall`=1 for one cycle.
  - Then `fwd_rs_d`=2 with `stall`=0.
- `lw $1` then `beq` rt=1: `stall`=1 for two consecutive cycles, then `fwd_rt_d`=3, and `stall_cnt`=2.
- `lw $0` then `addu` rs=0, rt=0: `stall`=0 and all fwd outputs 0 throughout.
- `addu $5` then `sw` rt=5 (tuse 2) with no stall:
  - Next cycle `fwd_rt_e`=1.
  - One cycle later `fwd_rt_m`=1.
- `lw $1` in E, `addu` rs=1 in D (`stall`=1); pulse `reset_n` low mid-cycle: `stall`=0 immediately, `stall_cnt`=0, and all fwd outputs 0.
